// File: rtl/instr_fetch_unit.sv
// Fetch stage for the RV32I core: issues sequential word fetches under a DEPTH-entry credit limit,
// queues in-order responses with their PC for decode, and flushes/drops stale data on redirect.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);
   localparam int unsigned   PW   = $clog2(DEPTH);
   localparam int unsigned   CW   = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic          rst_q;
   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] inflight;
   logic [CW-1:0] drop_cnt;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [31:0]   q_instr [DEPTH];
   logic [31:0]   q_pc    [DEPTH];

   logic [CW:0]   credit_used;
   logic          req_fire;
   logic          deq;
   logic          enq;
   logic          drop;
   logic [CW-1:0] inflight_next;

   // NOTE: every signal is assigned unconditionally at the top of this block, so no latch can be inferred.
   always_comb begin
      credit_used    = {1'b0, count} + {1'b0, inflight};
      imem_req_valid = !rst_q && !redirect_valid && (credit_used < {1'b0, FULL});
      imem_req_addr  = fetch_pc;
      req_fire       = imem_req_valid && imem_req_ready;
      id_valid       = (count != '0) && !redirect_valid;
      deq            = id_valid && id_ready;
      enq            = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
      drop           = imem_rsp_valid && (drop_cnt != '0);
      // Every response returns a credit, whether it is kept, dropped or lands in a redirect cycle.
      inflight_next  = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      id_instr       = q_instr[rd_ptr];
      id_pc          = q_pc[rd_ptr];
   end

   // Holds off requests for the first cycle after any reset cycle.
   always_ff @(posedge clk) begin
      rst_q <= rst;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         count    <= '0;
         inflight <= '0;
         drop_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         inflight <= inflight_next;
         if (redirect_valid) begin
            // Responses still owed by memory after this cycle belong to the old path.
            fetch_pc <= redirect_pc & ~32'd3;
            rsp_pc   <= redirect_pc & ~32'd3;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= inflight_next;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (drop)     drop_cnt <= drop_cnt - CW'(1);
            if (enq) begin
               rsp_pc <= rsp_pc + 32'd4;
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq)      rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(enq) - CW'(deq);
         end
      end
   end

   // NOTE: queue storage is reset so id_instr/id_pc read as zero until the first entry arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_instr <= '{default: '0};
         q_pc    <= '{default: '0};
      end else if (enq) begin
         q_instr[wr_ptr] <= imem_rsp_data;
         q_pc[wr_ptr]    <= rsp_pc;
      end
   end

   // The credit limit makes this unreachable; a hit means the credit logic is broken.
   assert property (@(posedge clk) disable iff (rst) !(enq && (count == FULL) && !deq));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order memory model with a scoreboard of expected
// decode-side {pc, instr} pairs, plus directed scenarios for credit, stall, redirect, reset and wrap.
module tb_instr_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam int unsigned DEPTH    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
   );

   typedef struct { logic [31:0] addr; logic [31:0] pc; int due; int tag; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   pend_t       pend[$];
   exp_t        exp_q[$];
   int          tests_run = 0;
   int          tests_failed = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          mem_lat = 1;
   logic        mem_stall = 1'b0;
   logic        req_fire;
   logic        id_fire;
   logic [31:0] exp_addr = RESET_PC;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   // Drive the memory response for this cycle and let combinational outputs settle.
   task automatic settle();
      if (!rst && !mem_stall && pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word_of(pend[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
      #1;
      req_fire = imem_req_valid && imem_req_ready;
      id_fire  = id_valid && id_ready;
   endtask

   // Update the model from this cycle's handshakes, then advance to the next negedge.
   task automatic commit();
      pend_t p;
      exp_t  e;
      int    d;
      if (rst) begin
         pend.delete();
         exp_q.delete();
         exp_addr = RESET_PC;
         epoch++;
      end else begin
         if (redirect_valid) begin
            epoch++;
            exp_q.delete();
         end
         if (id_fire) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL sb_id_unexpected: got pc=%h instr=%h expected no handshake", id_pc, id_instr);
            end else begin
               e = exp_q.pop_front();
               if (id_pc !== e.pc || id_instr !== e.instr) begin
                  tests_failed++;
                  $display("FAIL sb_id: got pc=%h instr=%h expected pc=%h instr=%h", id_pc, id_instr, e.pc, e.instr);
               end
            end
         end
         if (imem_rsp_valid) begin
            p = pend.pop_front();
            if (p.tag == epoch) exp_q.push_back('{p.pc, word_of(p.addr)});
         end
         if (req_fire) begin
            tests_run++;
            if (imem_req_addr !== exp_addr) begin
               tests_failed++;
               $display("FAIL sb_req_addr: got %h expected %h", imem_req_addr, exp_addr);
            end
            d = cyc + mem_lat;
            if (pend.size() > 0 && pend[$].due > d) d = pend[$].due;
            pend.push_back('{imem_req_addr, exp_addr, d, epoch});
            exp_addr = exp_addr + 32'd4;
         end
         if (redirect_valid) exp_addr = redirect_pc & ~32'd3;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic step();
      settle();
      commit();
   endtask

   task automatic do_reset();
      redirect_valid = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   // Accept n requests with responses held back, then stop issuing.
   task automatic fill_inflight(input int n);
      int acc = 0;
      imem_req_ready = 1'b1;
      for (int i = 0; i < 20 && acc < n; i++) begin
         settle();
         if (req_fire) acc++;
         commit();
      end
      imem_req_ready = 1'b0;
      tests_run++;
      if (acc != n) begin
         tests_failed++;
         $display("FAIL fill_accepts: got %0d expected %0d", acc, n);
      end
   endtask

   task automatic release_responses(input int n);
      mem_stall = 1'b0;
      for (int i = 0; i < n; i++) step();
      mem_stall = 1'b1;
   endtask

   // Wait (bounded) for the next decode handshake and compare its PC.
   task automatic expect_next_id_pc(input string name, input logic [31:0] want);
      logic        got = 1'b0;
      logic [31:0] seen = '0;
      for (int i = 0; i < 40 && !got; i++) begin
         settle();
         if (id_fire) begin
            got  = 1'b1;
            seen = id_pc;
         end
         commit();
      end
      tests_run++;
      if (!got || seen !== want) begin
         tests_failed++;
         $display("FAIL %s: got pc=%h (handshake=%0b) expected %h", name, seen, got, want);
      end
   endtask

   task automatic test_reset();
      imem_req_ready = 1'b1;
      id_ready = 1'b1;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      settle();
      tests_run++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_valids: got req_valid=%b id_valid=%b expected 0 0", imem_req_valid, id_valid);
      end
      tests_run++;
      if (imem_req_addr !== RESET_PC) begin
         tests_failed++;
         $display("FAIL reset_addr: got %h expected %h", imem_req_addr, RESET_PC);
      end
      tests_run++;
      if (id_instr !== 32'h0 || id_pc !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_id_regs: got instr=%h pc=%h expected 0 0", id_instr, id_pc);
      end
      commit();
      settle();
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
         tests_failed++;
         $display("FAIL reset_first_req: got valid=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
      end
      commit();
   endtask

   task automatic test_stream();
      int fires = 0;
      for (int i = 0; i < 3; i++) step();
      for (int i = 0; i < 20; i++) begin
         settle();
         if (id_fire) fires++;
         commit();
      end
      tests_run++;
      if (fires != 20) begin
         tests_failed++;
         $display("FAIL stream_throughput: got %0d handshakes expected 20", fires);
      end
   endtask

   task automatic test_backpressure();
      int          acc = 0;
      int          n_id = 0;
      logic [31:0] pcs [4];
      logic        resumed = 1'b0;
      logic [31:0] resume_addr = '0;
      id_ready = 1'b0;
      imem_req_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         settle();
         if (req_fire) acc++;
         commit();
      end
      settle();
      tests_run++;
      if (acc != 4 || imem_req_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_credit: got accepts=%0d req_valid=%b expected 4 0", acc, imem_req_valid);
      end
      commit();
      id_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         settle();
         if (id_fire && n_id < 4) begin
            pcs[n_id] = id_pc;
            n_id++;
         end
         if (req_fire && !resumed) begin
            resumed = 1'b1;
            resume_addr = imem_req_addr;
         end
         commit();
      end
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (k >= n_id || pcs[k] !== RESET_PC + 32'(4 * k)) begin
            tests_failed++;
            $display("FAIL bp_drain_pc%0d: got %h expected %h", k, pcs[k], RESET_PC + 32'(4 * k));
         end
      end
      tests_run++;
      if (!resumed || resume_addr !== 32'h0000_0110) begin
         tests_failed++;
         $display("FAIL bp_resume_addr: got %h (resumed=%0b) expected 00000110", resume_addr, resumed);
      end
   endtask

   task automatic test_req_stall();
      logic [31:0] held = '0;
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         if (i == 0) held = imem_req_addr;
         tests_run++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== held) begin
            tests_failed++;
            $display("FAIL stall_hold%0d: got valid=%b addr=%h expected 1 %h", i, imem_req_valid, imem_req_addr, held);
         end
         commit();
      end
      imem_req_ready = 1'b1;
      settle();
      tests_run++;
      if (!req_fire || imem_req_addr !== held) begin
         tests_failed++;
         $display("FAIL stall_accept: got fire=%b addr=%h expected 1 %h", req_fire, imem_req_addr, held);
      end
      commit();
      settle();
      tests_run++;
      if (imem_req_addr !== held + 32'd4) begin
         tests_failed++;
         $display("FAIL stall_next_addr: got %h expected %h", imem_req_addr, held + 32'd4);
      end
      commit();
   endtask

   task automatic test_redirect();
      id_ready = 1'b0;
      mem_stall = 1'b1;
      mem_lat = 1;
      imem_req_ready = 1'b1;
      do_reset();
      fill_inflight(3);
      release_responses(1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0203;
      id_ready = 1'b1;
      imem_req_ready = 1'b1;
      settle();
      tests_run++;
      if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL redir_suppress: got id_valid=%b req_valid=%b expected 0 0", id_valid, imem_req_valid);
      end
      commit();
      redirect_valid = 1'b0;
      redirect_pc = '0;
      mem_stall = 1'b0;
      settle();
      tests_run++;
      if (id_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL redir_flush: got id_valid=%b expected 0", id_valid);
      end
      tests_run++;
      if (!req_fire || imem_req_addr !== 32'h0000_0200) begin
         tests_failed++;
         $display("FAIL redir_req_addr: got fire=%b addr=%h expected 1 00000200", req_fire, imem_req_addr);
      end
      commit();
      expect_next_id_pc("redir_first_id_pc", 32'h0000_0200);
   endtask

   task automatic test_redirect_with_rsp();
      id_ready = 1'b0;
      mem_stall = 1'b1;
      imem_req_ready = 1'b1;
      do_reset();
      fill_inflight(3);
      release_responses(1);
      mem_stall = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0300;
      id_ready = 1'b1;
      imem_req_ready = 1'b1;
      settle();
      tests_run++;
      if (id_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL redir_rsp_no_deq: got id_valid=%b expected 0", id_valid);
      end
      commit();
      redirect_valid = 1'b0;
      redirect_pc = '0;
      expect_next_id_pc("redir_rsp_first_id_pc", 32'h0000_0300);
   endtask

   task automatic test_reset_mid();
      id_ready = 1'b0;
      mem_stall = 1'b1;
      imem_req_ready = 1'b1;
      do_reset();
      fill_inflight(4);
      release_responses(2);
      mem_stall = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      imem_req_ready = 1'b1;
      id_ready = 1'b1;
      settle();
      tests_run++;
      if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_idle: got id_valid=%b req_valid=%b expected 0 0", id_valid, imem_req_valid);
      end
      commit();
      settle();
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
         tests_failed++;
         $display("FAIL rst_mid_restart: got valid=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
      end
      commit();
      expect_next_id_pc("rst_mid_first_id_pc", RESET_PC);
   endtask

   task automatic test_wrap();
      imem_req_ready = 1'b1;
      id_ready = 1'b1;
      mem_stall = 1'b0;
      mem_lat = 1;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      redirect_pc = '0;
      settle();
      tests_run++;
      if (!req_fire || imem_req_addr !== 32'hFFFF_FFFC) begin
         tests_failed++;
         $display("FAIL wrap_req_last: got fire=%b addr=%h expected 1 fffffffc", req_fire, imem_req_addr);
      end
      commit();
      settle();
      tests_run++;
      if (imem_req_addr !== 32'h0000_0000) begin
         tests_failed++;
         $display("FAIL wrap_req_zero: got %h expected 00000000", imem_req_addr);
      end
      commit();
      expect_next_id_pc("wrap_id_last", 32'hFFFF_FFFC);
      expect_next_id_pc("wrap_id_zero", 32'h0000_0000);
   endtask

   task automatic test_back_to_back();
      int fires = 0;
      for (int i = 0; i < 400; i++) begin
         imem_req_ready = ($urandom_range(0, 3) != 0);
         id_ready       = ($urandom_range(0, 1) != 0);
         mem_stall      = ($urandom_range(0, 4) == 0);
         mem_lat        = $urandom_range(1, 3);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc    = 32'h0000_1000 + 32'($urandom_range(0, 255));
         settle();
         if (id_fire) fires++;
         commit();
      end
      redirect_valid = 1'b0;
      mem_stall = 1'b0;
      tests_run++;
      if (fires < 50) begin
         tests_failed++;
         $display("FAIL b2b_progress: got %0d handshakes expected at least 50", fires);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_req_stall();
      test_redirect();
      test_redirect_with_rsp();
      test_reset_mid();
      test_wrap();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
